// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA raster generator.
// Holds the per-axis timing record, two stock video modes and the
// axis-total helper used to size the counters.
package vga_pkg;

    localparam int COORD_W = 11;

    // One axis of a video mode: visible span followed by the three blanking parts.
    typedef struct packed {
        logic [COORD_W-1:0] active;
        logic [COORD_W-1:0] fp;
        logic [COORD_W-1:0] sync;
        logic [COORD_W-1:0] bp;
    } vga_timing_t;

    // A complete mode: horizontal axis in pixels, vertical axis in lines.
    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h: '{active: 11'd640, fp: 11'd16, sync: 11'd96,  bp: 11'd48},
        v: '{active: 11'd480, fp: 11'd10, sync: 11'd2,   bp: 11'd33}
    };

    localparam vga_mode_t VGA_800x600 = '{
        h: '{active: 11'd800, fp: 11'd40, sync: 11'd128, bp: 11'd88},
        v: '{active: 11'd600, fp: 11'd1,  sync: 11'd4,   bp: 11'd23}
    };

    // Full period of one axis (visible + porches + sync).
    function automatic int total(input vga_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/vga_timing_pipe_if.sv
// Video bus between renderer / frame buffer and the raster generator.
// master: the raster generator (drives fetch coordinates and DAC pins).
// slave : the renderer side (supplies colour for each fetch).
// Optional test_mode input exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_pipe_if #(
    parameter int COLOR_W = 8
);
    logic [COLOR_W-1:0] R;
    logic [COLOR_W-1:0] G;
    logic [COLOR_W-1:0] B;
`ifdef VGA_TEST_PATTERN_EN
    logic               test_mode;
`endif
    logic [10:0]        fetch_x;
    logic [10:0]        fetch_y;
    logic               fetch_valid;
    logic               pix_ce;
    logic               frame_start;
    logic [COLOR_W-1:0] VGA_R;
    logic [COLOR_W-1:0] VGA_G;
    logic [COLOR_W-1:0] VGA_B;
    logic               VGA_HS;
    logic               VGA_VS;
    logic               VGA_BLANK_N;
    logic               VGA_SYNC_N;

`ifdef VGA_TEST_PATTERN_EN
    modport master (
        input  R, G, B, test_mode,
        output fetch_x, fetch_y, fetch_valid, pix_ce, frame_start,
               VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
    modport slave (
        output R, G, B, test_mode,
        input  fetch_x, fetch_y, fetch_valid, pix_ce, frame_start,
               VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
`else
    modport master (
        input  R, G, B,
        output fetch_x, fetch_y, fetch_valid, pix_ce, frame_start,
               VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
    modport slave (
        output R, G, B,
        input  fetch_x, fetch_y, fetch_valid, pix_ce, frame_start,
               VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on en_i, flags the visible and sync
// regions of the current count and reports the enabled step that wraps.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_timing_t T = VGA_640x480.h
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    output logic [COORD_W-1:0] cnt_o,
    output logic               active_o,
    output logic               sync_o,
    output logic               wrap_o
);

    localparam logic [COORD_W-1:0] LAST    = COORD_W'(total(T) - 1);
    localparam logic [COORD_W-1:0] SYNC_LO = COORD_W'(int'(T.active) + int'(T.fp));
    localparam logic [COORD_W-1:0] SYNC_HI = COORD_W'(int'(T.active) + int'(T.fp) + int'(T.sync));

    logic [COORD_W-1:0] cnt_q;
    logic [COORD_W-1:0] cnt_d;

    assign wrap_o   = en_i && (cnt_q == LAST);
    assign active_o = (cnt_q < T.active);
    assign sync_o   = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
    assign cnt_o    = cnt_q;

    // Next count: hold, step, or fold back to zero after the last position.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + COORD_W'(1);
        end
    end

    // Position register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster generator with a colour path.
// Issues fetch coordinates LEAD pixel ticks ahead of display and delays
// sync/blank through a matching pipe so returned RGB lines up at the pins.
// Optional feature: define VGA_TEST_PATTERN_EN to add test_mode, which
// replaces the RGB inputs with eight vertical colour bars.
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int COLOR_W  = 8,
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int LEAD     = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_pipe_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam vga_timing_t H_TIM = '{active: 11'(H_ACTIVE), fp: 11'(H_FP),
                                      sync: 11'(H_SYNC), bp: 11'(H_BP)};
    localparam vga_timing_t V_TIM = '{active: 11'(V_ACTIVE), fp: 11'(V_FP),
                                      sync: 11'(V_SYNC), bp: 11'(V_BP)};

    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef VGA_TEST_PATTERN_EN
    localparam int PW = COORD_W + 3;
`else
    localparam int PW = 3;
`endif

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_pipe: CLK_DIV must be >= 1");
    end
    if (LEAD < 0 || LEAD > 15) begin : g_bad_lead
        $error("vga_timing_pipe: LEAD must be in 0..15");
    end
    if (H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_bad_total
        $error("vga_timing_pipe: H_TOTAL and V_TOTAL must be < 2048");
    end

    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic               h_act, v_act, h_sync, v_sync, h_wrap, v_wrap;
    logic               first_q;
    logic [PW-1:0]      raw_vec, tail_vec;

    assign tick = (div_q == DIV_LAST);

    // Pixel-rate divider; with CLK_DIV=1 it stays at zero and ticks every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    vga_axis_counter #(.T(H_TIM)) u_h (
        .clk     (clk),
        .rst     (rst),
        .en_i    (tick),
        .cnt_o   (h_cnt),
        .active_o(h_act),
        .sync_o  (h_sync),
        .wrap_o  (h_wrap)
    );

    vga_axis_counter #(.T(V_TIM)) u_v (
        .clk     (clk),
        .rst     (rst),
        .en_i    (h_wrap),
        .cnt_o   (v_cnt),
        .active_o(v_act),
        .sync_o  (v_sync),
        .wrap_o  (v_wrap)
    );

    // Marks that the coming tick is raw (0,0): set out of reset and after the
    // last tick of every frame, so no wide zero-compare is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b1;
        end else if (tick) begin
            first_q <= v_wrap;
        end
    end

    // Pipe entry layout, LSB first: active, vsync, hsync, [column].
`ifdef VGA_TEST_PATTERN_EN
    assign raw_vec = {h_cnt, h_sync, v_sync, h_act & v_act};
`else
    assign raw_vec = {h_sync, v_sync, h_act & v_act};
`endif

    if (LEAD == 0) begin : g_direct
        assign tail_vec = raw_vec;
    end else begin : g_pipe
        logic [PW-1:0] pipe_q [LEAD];

        // LEAD-deep delay advanced per pixel tick; all-zero entries mean blank, sync idle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LEAD; i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (tick) begin
                pipe_q[0] <= raw_vec;
                for (int i = 1; i < LEAD; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign tail_vec = pipe_q[LEAD-1];
    end

    logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
    logic [COORD_W-1:0] tail_x;
    logic [2:0]         bar;

    assign tail_x = tail_vec[PW-1:3];
    assign bar    = 3'((int'(tail_x) * 8) / H_ACTIVE);

    // Bars white, yellow, cyan, green, magenta, red, blue, black: each channel
    // turns out to be the inverse of one bar-index bit.
    always_comb begin
        src_r = vif.R;
        src_g = vif.G;
        src_b = vif.B;
        if (vif.test_mode) begin
            src_r = {COLOR_W{~bar[1]}};
            src_g = {COLOR_W{~bar[2]}};
            src_b = {COLOR_W{~bar[0]}};
        end
    end
`else
    assign src_r = vif.R;
    assign src_g = vif.G;
    assign src_b = vif.B;
`endif

    logic               hs_d, vs_d, blank_n_d;
    logic [COLOR_W-1:0] r_d, g_d, b_d;

    // Output-stage next values from the pipe tail; colour forced to 0 while blanked.
    always_comb begin
        hs_d      = tail_vec[2] ? HS_ACT : ~HS_ACT;
        vs_d      = tail_vec[1] ? VS_ACT : ~VS_ACT;
        blank_n_d = tail_vec[0];
        r_d       = '0;
        g_d       = '0;
        b_d       = '0;
        if (tail_vec[0]) begin
            r_d = src_r;
            g_d = src_g;
            b_d = src_b;
        end
    end

    logic [COORD_W-1:0] fetch_x_q, fetch_y_q;
    logic               fetch_valid_q, pix_ce_q, frame_start_q;
    logic               hs_q, vs_q, blank_n_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q;

    // Output registers: strobes every clock, everything else loads on the tick and holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            fetch_valid_q <= 1'b0;
            pix_ce_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hs_q          <= ~HS_ACT;
            vs_q          <= ~VS_ACT;
            blank_n_q     <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            pix_ce_q      <= tick;
            frame_start_q <= tick & first_q;
            if (tick) begin
                fetch_x_q     <= h_cnt;
                fetch_y_q     <= v_cnt;
                fetch_valid_q <= h_act & v_act;
                hs_q          <= hs_d;
                vs_q          <= vs_d;
                blank_n_q     <= blank_n_d;
                r_q           <= r_d;
                g_q           <= g_d;
                b_q           <= b_d;
            end
        end
    end

    assign vif.fetch_x     = fetch_x_q;
    assign vif.fetch_y     = fetch_y_q;
    assign vif.fetch_valid = fetch_valid_q;
    assign vif.pix_ce      = pix_ce_q;
    assign vif.frame_start = frame_start_q;
    assign vif.VGA_HS      = hs_q;
    assign vif.VGA_VS      = vs_q;
    assign vif.VGA_BLANK_N = blank_n_q;
    assign vif.VGA_R       = r_q;
    assign vif.VGA_G       = g_q;
    assign vif.VGA_B       = b_q;
    assign vif.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: two instances on a reduced 16x6 raster.
// dut0: CLK_DIV=2, LEAD=2, negative syncs. dut1: CLK_DIV=1, LEAD=0, positive syncs.
// A tick-index model predicts every output on every clock; a few literal
// checks pin the model (first tick, frame length, sync widths).
module tb_vga_timing_pipe;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 2, HT = 23;
    localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1, VT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic       tm = 1'b0;
    logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;

    always #5 clk = ~clk;

    vga_timing_pipe_if #(.COLOR_W(8)) if0 ();
    vga_timing_pipe_if #(.COLOR_W(8)) if1 ();

    assign if0.R = r_in;
    assign if0.G = g_in;
    assign if0.B = b_in;
    assign if1.R = r_in;
    assign if1.G = g_in;
    assign if1.B = b_in;
`ifdef VGA_TEST_PATTERN_EN
    assign if0.test_mode = tm;
    assign if1.test_mode = tm;
`endif

    vga_timing_pipe #(
        .COLOR_W(8), .CLK_DIV(2),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(0), .VS_POL(0), .LEAD(2)
    ) dut0 (.clk(clk), .rst(rst), .vif(if0.master));

    vga_timing_pipe #(
        .COLOR_W(8), .CLK_DIV(1),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1), .VS_POL(1), .LEAD(0)
    ) dut1 (.clk(clk), .rst(rst), .vif(if1.master));

    typedef struct {
        int fx, fy, fv, ce, fs, hs, vs, bn, r, g, b, sn;
    } vid_t;

    vid_t ex [2];
    vid_t ob [2];
    int   cyc  [2] = '{0, 0};
    int   cdiv [2] = '{2, 1};
    int   lead [2] = '{2, 0};
    int   hpol [2] = '{0, 1};
    int   vpol [2] = '{0, 1};
    logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                3'b101, 3'b100, 3'b001, 3'b000};

    int errors = 0;
    int checks = 0;
    int tk0 = 0, last_fs = -1, hs_run = 0, vs_run = 0, fs_pairs = 0;

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, d, $time, act, exp);
        end
    endtask

    function automatic vid_t reset_vals(input int d);
        vid_t v;
        v = '{0, 0, 0, 0, 0, 1 - hpol[d], 1 - vpol[d], 0, 0, 0, 0, 0};
        return v;
    endfunction

    // Expected outputs for pixel tick n (0 = first tick after reset).
    task automatic model_tick(input int d, input int n);
        int h, v, m, hm, vm, bar;
        bit act, hsr, vsr;
        h = n % HT;
        v = (n / HT) % VT;
        ex[d].fx = h;
        ex[d].fy = v;
        ex[d].fv = (h < HA && v < VA) ? 1 : 0;
        ex[d].ce = 1;
        ex[d].fs = (h == 0 && v == 0) ? 1 : 0;
        act = 0; hsr = 0; vsr = 0; hm = 0;
        if (n >= lead[d]) begin
            m   = n - lead[d];
            hm  = m % HT;
            vm  = (m / HT) % VT;
            act = (hm < HA && vm < VA);
            hsr = (hm >= HA + HFP && hm < HA + HFP + HSY);
            vsr = (vm >= VA + VFP && vm < VA + VFP + VSY);
        end
        ex[d].hs = hsr ? hpol[d] : 1 - hpol[d];
        ex[d].vs = vsr ? vpol[d] : 1 - vpol[d];
        ex[d].bn = act ? 1 : 0;
        ex[d].r = 0; ex[d].g = 0; ex[d].b = 0;
        if (act) begin
            if (tm) begin
                bar = hm * 8 / HA;
                ex[d].r = bar_tab[bar][2] ? 255 : 0;
                ex[d].g = bar_tab[bar][1] ? 255 : 0;
                ex[d].b = bar_tab[bar][0] ? 255 : 0;
            end else begin
                ex[d].r = int'(r_in);
                ex[d].g = int'(g_in);
                ex[d].b = int'(b_in);
            end
        end
    endtask

    // Single compare process: advance the model, check both DUTs, literal checks.
    always @(negedge clk) begin
        ob[0] = '{int'(if0.fetch_x), int'(if0.fetch_y), int'(if0.fetch_valid), int'(if0.pix_ce),
                  int'(if0.frame_start), int'(if0.VGA_HS), int'(if0.VGA_VS), int'(if0.VGA_BLANK_N),
                  int'(if0.VGA_R), int'(if0.VGA_G), int'(if0.VGA_B), int'(if0.VGA_SYNC_N)};
        ob[1] = '{int'(if1.fetch_x), int'(if1.fetch_y), int'(if1.fetch_valid), int'(if1.pix_ce),
                  int'(if1.frame_start), int'(if1.VGA_HS), int'(if1.VGA_VS), int'(if1.VGA_BLANK_N),
                  int'(if1.VGA_R), int'(if1.VGA_G), int'(if1.VGA_B), int'(if1.VGA_SYNC_N)};
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                cyc[d] = 0;
                ex[d]  = reset_vals(d);
            end else begin
                cyc[d]++;
                if (cyc[d] % cdiv[d] == 0) begin
                    model_tick(d, cyc[d] / cdiv[d] - 1);
                end else begin
                    ex[d].ce = 0;
                    ex[d].fs = 0;
                end
            end
            chk("fetch_x", d, ob[d].fx, ex[d].fx);
            chk("fetch_y", d, ob[d].fy, ex[d].fy);
            chk("fetch_valid", d, ob[d].fv, ex[d].fv);
            chk("pix_ce", d, ob[d].ce, ex[d].ce);
            chk("frame_start", d, ob[d].fs, ex[d].fs);
            chk("VGA_HS", d, ob[d].hs, ex[d].hs);
            chk("VGA_VS", d, ob[d].vs, ex[d].vs);
            chk("VGA_BLANK_N", d, ob[d].bn, ex[d].bn);
            chk("VGA_R", d, ob[d].r, ex[d].r);
            chk("VGA_G", d, ob[d].g, ex[d].g);
            chk("VGA_B", d, ob[d].b, ex[d].b);
            chk("VGA_SYNC_N", d, ob[d].sn, ex[d].sn);
        end

        if (rst) begin
            tk0 = 0; last_fs = -1; hs_run = 0; vs_run = 0;
        end else begin
            if (cyc[0] == 1) chk("lit_no_tick_clk1", 0, ob[0].ce, 0);
            if (cyc[0] == 2) begin
                chk("lit_first_tick_ce", 0, ob[0].ce, 1);
                chk("lit_first_tick_fs", 0, ob[0].fs, 1);
                chk("lit_first_tick_fx", 0, ob[0].fx, 0);
                chk("lit_first_tick_fy", 0, ob[0].fy, 0);
            end
            if (ob[0].ce == 1) begin
                tk0++;
                if (ob[0].fs == 1) begin
                    if (last_fs >= 0) begin
                        chk("lit_frame_len", 0, tk0 - last_fs, 230);
                        fs_pairs++;
                    end
                    last_fs = tk0;
                end
                if (ob[0].hs == 0) hs_run++;
                else begin
                    if (hs_run > 0) chk("lit_hs_width", 0, hs_run, 3);
                    hs_run = 0;
                end
                if (ob[0].vs == 0) vs_run++;
                else begin
                    if (vs_run > 0) chk("lit_vs_width", 0, vs_run, 46);
                    vs_run = 0;
                end
            end
        end

        if (done) begin
            chk("frames_observed", 0, (fs_pairs >= 2) ? 1 : 0, 1);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Stimulus: random colour each clock, one mid-frame reset, optional test-pattern phase.
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3600; k++) begin
            @(negedge clk);
            #1;
            r_in = 8'($urandom);
            g_in = 8'($urandom);
            b_in = 8'($urandom);
            if (k == 1203) rst = 1'b1;
            if (k == 1206) rst = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            tm = (k >= 2400);
`endif
        end
        done = 1'b1;
    end

endmodule
